fp_iter_unit: RTL

Parametrised, multi-cycle floating-point add/subtract/multiply unit with its own control FSM and datapath.
- Operands use an IEEE-754-style layout: sign, EXP_W-bit biased exponent, MAN_W-bit fraction with hidden bit.
- Sits beside the integer ALU; the core issues one operation at a time through a start/done handshake.
- Adds: effective subtraction (different signs), iterative normalisation, special-value handling, status flags, and configurable rounding.

---
 rtl/fp_iter_unit.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_iter_unit.sv
// rtl/fp_iter_unit.sv - multi-cycle floating-point add/sub/mul unit with start/done handshake
// Define FP_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_iter_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int SW = MAN_W + 5;          // carry, hidden, fraction, guard, round, sticky
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 1);
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE     = XW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [3:0] IDLE = 4'd0, LOAD = 4'd1, ALIGN = 4'd2, ADD = 4'd3, MUL = 4'd4,
                         NORM = 4'd5, ROUND = 4'd6, RENORM = 4'd7, DONE = 4'd8;

  logic [3:0] state;
  logic [1:0] opR;
  logic [W-1:0] aR, bR, pend;
  logic pendOvf, pendUnf, pendInv;
  logic sBig, sSmall, rSign, normFirst;
  logic signed [XW-1:0] ex;
  logic [SW-1:0] sig, opA, opB;
  logic [PW-1:0] acc, mulA, accNext;
  logic [MAN_W:0] mulB;
  logic [CW-1:0] cnt;

  logic sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0] ma, mb;
  logic aZero, bZero, aInf, bInf, aNan, bNan, isMul;
  assign {sa, ea, fa} = aR;
  assign {sb, eb, fb} = bR;
  assign ma    = {1'b1, fa};
  assign mb    = {1'b1, fb};
  assign aZero = (ea == '0);
  assign bZero = (eb == '0);
  assign aInf  = (&ea) && (fa == '0);
  assign bInf  = (&eb) && (fb == '0);
  assign aNan  = (&ea) && (fa != '0);
  assign bNan  = (&eb) && (fb != '0);
  assign isMul = (opR == 2'b10);
  assign busy  = (state != IDLE) && (state != DONE);

  logic specHit, specInv;
  logic [W-1:0] specVal;
  always_comb begin
    specHit = 1'b1;
    specInv = 1'b0;
    specVal = '0;
    if (opR == 2'b11 || aNan || bNan || (!isMul && aInf && bInf && sa != sb) ||
        (isMul && ((aInf && bZero) || (aZero && bInf)))) begin
      specInv = 1'b1;
      specVal = QNAN;
    end else if (aInf || bInf) begin
      specVal = {isMul ? (sa ^ sb) : (aInf ? sa : sb), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (aZero || bZero) begin
      if (isMul)
        specVal = {sa ^ sb, {(W-1){1'b0}}};
      else if (aZero)
        specVal = bZero ? {sb, {(W-1){1'b0}}} : bR;
      else
        specVal = aR;
    end else begin
      specHit = 1'b0;
    end
  end

  logic aBig, lost;
  logic [EXP_W-1:0] eDiff;
  logic [SW-1:0] extBig, extSmall, shifted;
  assign aBig     = (ea >= eb);
  assign eDiff    = aBig ? (ea - eb) : (eb - ea);
  assign extBig   = {1'b0, aBig ? ma : mb, 3'b000};
  assign extSmall = {1'b0, aBig ? mb : ma, 3'b000};
  always_comb begin
    shifted = '0;
    lost    = 1'b1;
    if (int'(eDiff) < MAN_W + 3) begin
      shifted = extSmall >> eDiff;
      lost    = |(extSmall & ~({SW{1'b1}} << eDiff));
    end
  end

  logic bGreater;
  logic [SW-1:0] sum, diff;
  assign sum      = opA + opB;
  assign bGreater = (opB > opA);
  assign diff     = bGreater ? (opB - opA) : (opA - opB);
  assign accNext  = acc + (mulB[0] ? mulA : '0);

  logic up;
  logic [MAN_W:0] rndFrac;
`ifdef FP_ROUND_NEAREST_EN
  assign up = sig[2] & (sig[1] | sig[0] | sig[3]);
`else
  assign up = 1'b0;
`endif
  assign rndFrac = {1'b0, sig[MAN_W+2:3]} + {{MAN_W{1'b0}}, up};

  // Returns {overflow, underflow, packed value} after the range checks.
  function automatic logic [W+1:0] finish(input logic s, input logic signed [XW-1:0] e,
                                          input logic [MAN_W-1:0] f);
    if (e >= EXP_MAX)
      return {2'b10, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e <= 0)
      return {2'b01, s, {(W-1){1'b0}}};
    else
      return {2'b00, s, e[EXP_W-1:0], f};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;  done <= 1'b0;  result <= '0;
      overflow <= 1'b0;  underflow <= 1'b0;  invalid <= 1'b0;
      opR <= '0;  aR <= '0;  bR <= '0;  pend <= '0;
      pendOvf <= 1'b0;  pendUnf <= 1'b0;  pendInv <= 1'b0;
      sBig <= 1'b0;  sSmall <= 1'b0;  rSign <= 1'b0;  normFirst <= 1'b0;
      ex <= '0;  sig <= '0;  opA <= '0;  opB <= '0;
      acc <= '0;  mulA <= '0;  mulB <= '0;  cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          aR  <= a;
          bR  <= (op == 2'b01) ? {~b[W-1], b[W-2:0]} : b;
          opR <= op;
          overflow <= 1'b0;  underflow <= 1'b0;  invalid <= 1'b0;
          state <= LOAD;
        end
        LOAD: if (specHit) begin
          pend <= specVal;  pendInv <= specInv;  pendOvf <= 1'b0;  pendUnf <= 1'b0;
          state <= DONE;
        end else if (isMul) begin
          // The first multiplier bit is consumed here, leaving MAN_W steps for MUL.
          rSign <= sa ^ sb;
          ex    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
          acc   <= mb[0] ? {{(PW-MAN_W-1){1'b0}}, ma} : '0;
          mulA  <= {{(PW-MAN_W-1){1'b0}}, ma} << 1;
          mulB  <= mb >> 1;
          cnt   <= '0;
          state <= MUL;
        end else begin
          state <= ALIGN;
        end
        ALIGN: begin
          opA    <= extBig;
          opB    <= shifted | {{(SW-1){1'b0}}, lost};
          sBig   <= aBig ? sa : sb;
          sSmall <= aBig ? sb : sa;
          ex     <= $signed({2'b00, aBig ? ea : eb});
          state  <= ADD;
        end
        ADD: begin
          normFirst <= 1'b1;
          if (sBig == sSmall) begin
            sig <= sum;  rSign <= sBig;  state <= NORM;
          end else if (opA == opB) begin
            pend <= '0;  pendInv <= 1'b0;  pendOvf <= 1'b0;  pendUnf <= 1'b0;
            state <= DONE;
          end else begin
            sig <= diff;  rSign <= bGreater ? sSmall : sBig;  state <= NORM;
          end
        end
        MUL: begin
          acc  <= accNext;
          mulA <= mulA << 1;
          mulB <= mulB >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(MAN_W - 1)) begin
            sig <= {accNext[PW-1:MAN_W-2], |accNext[MAN_W-3:0]};
            normFirst <= 1'b1;
            state <= NORM;
          end
        end
        NORM: begin
          normFirst <= 1'b0;
          if (normFirst) begin
            if (sig[SW-1]) begin
              sig <= {1'b0, sig[SW-1:2], sig[1] | sig[0]};
              ex  <= ex + ONE;
              state <= ROUND;
            end else if (sig[SW-2]) begin
              state <= ROUND;
            end
          end else begin
            sig <= sig << 1;
            ex  <= ex - ONE;
            if (sig[SW-3]) state <= ROUND;
          end
        end
        ROUND: if (rndFrac[MAN_W]) begin
          sig   <= {2'b10, rndFrac[MAN_W-1:0], 3'b000};
          state <= RENORM;
        end else begin
          {pendOvf, pendUnf, pend} <= finish(rSign, ex, rndFrac[MAN_W-1:0]);
          pendInv <= 1'b0;
          state <= DONE;
        end
        RENORM: begin
          {pendOvf, pendUnf, pend} <= finish(rSign, ex + ONE, sig[MAN_W+3:4]);
          pendInv <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          result    <= pend;
          overflow  <= pendOvf;
          underflow <= pendUnf;
          invalid   <= pendInv;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
